// File: rtl/fmul_pipe.sv
// Three-stage IEEE-754 single-precision multiplier with valid/ready flow control.
// Exponent-0 operands flush to zero; exponent-255 operands (inf/NaN) yield signed infinity.
module fmul_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y
);

   logic               en;

   logic               vld_p1_q;
   logic               vld_p2_q;
   logic               vld_p3_q;

   logic               sign_p1_d;
   logic signed [9:0]  exp_p1_d;
   logic               zero_p1_d;
   logic               spec_p1_d;

   logic               sign_p1_q;
   logic signed [9:0]  exp_p1_q;
   logic               zero_p1_q;
   logic               spec_p1_q;
   logic [23:0]        sig1_p1_q;
   logic [23:0]        sig2_p1_q;

   logic [47:0]        prod_p2_d;
   logic               sign_p2_q;
   logic signed [9:0]  exp_p2_q;
   logic               zero_p2_q;
   logic               spec_p2_q;
   logic [47:0]        prod_p2_q;

   logic [31:0]        y_d;
   logic [31:0]        y_q;

   // Round-to-nearest-even on a 23-bit fraction; bit 23 of the result is the carry-out.
   function automatic logic [23:0] rne(input logic [22:0] mant, input logic g, input logic st);
      logic inc;
      inc = g && (st || mant[0]);
      return {1'b0, mant} + {23'h0, inc};
   endfunction

   // Final packing with class priority: special > zero > overflow > underflow > normal.
   function automatic logic [31:0] sat_pack(input logic sign, input logic signed [9:0] e,
                                            input logic [22:0] mant, input logic spec,
                                            input logic zero);
      logic [31:0] r;
      if (spec)
         r = {sign, 8'hFF, 23'h0};
      else if (zero)
         r = {sign, 31'h0};
      else if (e >= 10'sd255)
         r = {sign, 8'hFF, 23'h0};
      else if (e <= 10'sd0)
         r = {sign, 31'h0};
      else
         r = {sign, e[7:0], mant};
      return r;
   endfunction

   assign en        = !vld_p3_q || out_ready;
   assign in_ready  = en;
   assign out_valid = vld_p3_q;
   assign y         = y_q;

   // Stage 1: operand classification and biased exponent sum
   always_comb begin
      sign_p1_d = x1[31] ^ x2[31];
      exp_p1_d  = $signed({2'b00, x1[30:23]}) + $signed({2'b00, x2[30:23]}) - 10'sd127;
      zero_p1_d = (x1[30:23] == 8'h00) || (x2[30:23] == 8'h00);
      spec_p1_d = (x1[30:23] == 8'hFF) || (x2[30:23] == 8'hFF);
   end

   // Stage 2: full significand product
   assign prod_p2_d = 48'(sig1_p1_q) * 48'(sig2_p1_q);

   // Stage 3: normalize by one position, round, pack
   always_comb begin
      logic [22:0]       mant;
      logic              g;
      logic              st;
      logic [23:0]       mr;
      logic signed [9:0] e;
      if (prod_p2_q[47]) begin
         mant = prod_p2_q[46:24];
         g    = prod_p2_q[23];
         st   = |prod_p2_q[22:0];
         e    = exp_p2_q + 10'sd1;
      end else begin
         mant = prod_p2_q[45:23];
         g    = prod_p2_q[22];
         st   = |prod_p2_q[21:0];
         e    = exp_p2_q;
      end
      mr = rne(mant, g, st);
      if (mr[23])
         e = e + 10'sd1;
      y_d = sat_pack(sign_p2_q, e, mr[22:0], spec_p2_q, zero_p2_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         y_q      <= 32'h0;
      end else if (en) begin
         vld_p1_q <= in_valid;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
         if (vld_p2_q)
            y_q <= y_d;
      end
   end

   // Data stages only capture real transfers so idle-cycle operands never reach y.
   always_ff @(posedge clk) begin
      if (en && in_valid) begin
         sign_p1_q <= sign_p1_d;
         exp_p1_q  <= exp_p1_d;
         zero_p1_q <= zero_p1_d;
         spec_p1_q <= spec_p1_d;
         sig1_p1_q <= {1'b1, x1[22:0]};
         sig2_p1_q <= {1'b1, x2[22:0]};
      end
      if (en && vld_p1_q) begin
         sign_p2_q <= sign_p1_q;
         exp_p2_q  <= exp_p1_q;
         zero_p2_q <= zero_p1_q;
         spec_p2_q <= spec_p1_q;
         prod_p2_q <= prod_p2_d;
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: directed vectors, backpressure, mid-flight reset and an exponent sweep,
// all scored against a rational-arithmetic RNE model of the single-precision product.
module tb_fmul_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] x1 = 32'h0;
   logic [31:0] x2 = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] y;

   int          n_chk = 0;
   int          n_fail = 0;
   int          mode = 0;          // 0: always ready, 1: random ready, 2: never ready
   logic [31:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_y = 32'h0;

   fmul_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x1        (x1),
      .x2        (x2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Exact significand product, then round the value to 24 significant bits with RNE.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic              s;
      int                ea, eb, k, sh, e;
      longint unsigned   p, q, rem, half;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
      if (ea == 0 || eb == 0) return {s, 31'h0};
      p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      k    = (p >= (64'd1 << 47)) ? 47 : 46;
      sh   = k - 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      e = ea + eb - 127 + (k - 46);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rand_norm();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
   endfunction

   initial forever begin
      @(posedge clk);
      #1;
      case (mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Scoreboard: expected results enter on input transfers, leave on output transfers.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_vld", {31'h0, out_valid}, 32'h1);
            chk("stall_y", y, prev_y);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
               chk("spurious_out", {31'h0, out_valid}, 32'h0);
            else
               chk("result", y, exp_q.pop_front());
         end
         if (in_valid && in_ready)
            exp_q.push_back(ref_mul(x1, x2));
         prev_stall = out_valid && !out_ready;
         prev_y     = y;
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int n;
      x1 = a;
      x2 = b;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 1000);
      if (!in_ready) chk("send_timeout", {31'h0, in_ready}, 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x1 = $urandom;
      x2 = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'h0);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] dir_a[8] = '{32'h3FC00000, 32'hBF800000, 32'h3FC00000, 32'h3F800001,
                             32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000};
   logic [31:0] dir_b[8] = '{32'h40000000, 32'h3F800000, 32'h3F800001, 32'h3F800001,
                             32'h7F000000, 32'h00800000, 32'h3F800000, 32'h00000000};
   logic [31:0] dir_y[8] = '{32'h40400000, 32'hBF800000, 32'h3FC00002, 32'h3F800002,
                             32'h7F800000, 32'h00000000, 32'h80000000, 32'h7F800000};
   logic [22:0] corners[7] = '{23'h000000, 23'h000001, 23'h000002, 23'h3C0000,
                               23'h400000, 23'h5FFFFF, 23'h7FFFFF};

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_y", y, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed: the result is visible after the third rising edge, counting the accepting edge.
      for (int i = 0; i < 8; i++) begin
         send(dir_a[i], dir_b[i]);
         @(negedge clk);
         chk("lat_e1", {31'h0, out_valid}, 32'h0);
         @(negedge clk);
         chk("lat_e2", {31'h0, out_valid}, 32'h0);
         @(negedge clk);
         chk("lat_e3", {31'h0, out_valid}, 32'h1);
         chk("directed_y", y, dir_y[i]);
         @(posedge clk);
         #1;
      end
      drain();

      // Backpressure with random ready and random input gaps.
      mode = 1;
      for (int i = 0; i < 8; i++) begin
         send(rand_norm(), rand_norm());
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      mode = 0;

      // Mid-flight reset: three results in flight, the first one stalled at the output.
      mode = 2;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      send(rand_norm(), rand_norm());
      send(rand_norm(), rand_norm());
      send(rand_norm(), rand_norm());
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("midrst_y", y, 32'h0);
      chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
      exp_q.delete();
      mode = 0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         x1 = $urandom;
         x2 = $urandom;
         @(negedge clk);
         chk("postrst_vld", {31'h0, out_valid}, 32'h0);
         chk("postrst_y", y, 32'h0);
      end
      @(posedge clk);
      #1;

      // Sweep all normal exponent pairs with corner and random mantissas.
      for (int ea = 1; ea <= 254; ea++) begin
         for (int eb = 1; eb <= 254; eb++) begin
            int          ia, ib;
            logic [22:0] ma, mb;
            ia = (ea + eb * 3) % 8;
            ib = (ea * 5 + eb) % 8;
            ma = (ia < 7) ? corners[ia] : 23'($urandom);
            mb = (ib < 7) ? corners[ib] : 23'($urandom);
            send({1'($urandom_range(0, 1)), 8'(ea), ma}, {1'($urandom_range(0, 1)), 8'(eb), mb});
         end
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached with %0d failures", n_fail);
      $fatal(1);
   end

endmodule
